// File: rtl/enemy_fire_scheduler.sv
// enemy_fire_scheduler
//
// Arbitrates enemy fire requests onto a small pool of shared bullet slots.
// One spawn is outstanding at a time. A round-robin winner, the lowest free
// slot and the offset, clamped start position are captured together. They are
// then presented on a valid/ready handshake. The accepted enemy receives a
// one-cycle grant pulse.
//
// Optional feature: define ENEMY_FIRE_COOLDOWN_EN to insert a COOLDOWN_CYCLES
// dead time after every accepted spawn. In the default build this feature is
// disabled and no cooldown counter exists.
//
// Ports
//   clk25        in   system clock, rising edge
//   rst          in   asynchronous active-high reset
//   fire_req     in   [ENEMY_COUNT]     level request per enemy
//   enemy_x_flat in   [10*ENEMY_COUNT]  enemy i x at [i*10 +: 10]
//   enemy_y_flat in   [10*ENEMY_COUNT]  enemy i y at [i*10 +: 10]
//   slot_busy    in   [SLOT_COUNT]      slot s currently in flight
//   spawn_ready  in   bullet pool accepts the presented spawn
//   spawn_valid  out  spawn command presented
//   spawn_slot   out  target slot index
//   spawn_x      out  bullet start x
//   spawn_y      out  bullet start y
//   fire_grant   out  [ENEMY_COUNT]     one-hot pulse to the accepted enemy

module enemy_fire_scheduler #(
  parameter int unsigned ENEMY_COUNT     = 8,
  parameter int unsigned SLOT_COUNT      = 4,
  parameter int unsigned COOLDOWN_CYCLES = 25000
) (
  input  logic                          clk25,
  input  logic                          rst,
  input  logic [ENEMY_COUNT-1:0]        fire_req,
  input  logic [10*ENEMY_COUNT-1:0]     enemy_x_flat,
  input  logic [10*ENEMY_COUNT-1:0]     enemy_y_flat,
  input  logic [SLOT_COUNT-1:0]         slot_busy,
  input  logic                          spawn_ready,
  output logic                          spawn_valid,
  output logic [$clog2(SLOT_COUNT)-1:0] spawn_slot,
  output logic [9:0]                    spawn_x,
  output logic [9:0]                    spawn_y,
  output logic [ENEMY_COUNT-1:0]        fire_grant
);

  localparam int unsigned EW = (ENEMY_COUNT > 1) ? $clog2(ENEMY_COUNT) : 1;
  localparam int unsigned SW = $clog2(SLOT_COUNT);

  localparam logic [10:0] XOffset = 11'd12;
  localparam logic [10:0] YOffset = 11'd16;
  localparam logic [10:0] XMax    = 11'd639;
  localparam logic [10:0] YMax    = 11'd479;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StSpawn    = 2'd1,
    StCooldown = 2'd2
  } state_e;

  state_e                 r_state;
  logic [EW-1:0]          r_rr_ptr;
  logic [EW-1:0]          r_win;
  logic                   r_spawn_valid;
  logic [SW-1:0]          r_spawn_slot;
  logic [9:0]             r_spawn_x;
  logic [9:0]             r_spawn_y;
  logic [ENEMY_COUNT-1:0] r_fire_grant;

`ifdef ENEMY_FIRE_COOLDOWN_EN
  localparam int unsigned CW = (COOLDOWN_CYCLES > 1) ? $clog2(COOLDOWN_CYCLES) : 1;
  logic [CW-1:0] r_cool_cnt;
`else
  // Cooldown length only matters when the cooldown feature is built in.
  logic w_unused_cfg;
  assign w_unused_cfg = (COOLDOWN_CYCLES == 0);
`endif

  // Round-robin winner: scan upward starting just after the last winner.
  logic          w_req_any;
  logic          w_win_found;
  logic [EW-1:0] w_win_idx;

  assign w_req_any = |fire_req;

  always_comb begin
    int idx;
    idx         = 0;
    w_win_found = 1'b0;
    w_win_idx   = '0;
    for (int k = 1; k <= int'(ENEMY_COUNT); k++) begin
      idx = (int'(r_rr_ptr) + k) % int'(ENEMY_COUNT);
      if (!w_win_found && fire_req[idx]) begin
        w_win_found = 1'b1;
        w_win_idx   = EW'(idx);
      end
    end
  end

  // Lowest free slot: scan downward so the last hit is the lowest index.
  logic          w_slot_found;
  logic [SW-1:0] w_slot_idx;

  always_comb begin
    w_slot_found = 1'b0;
    w_slot_idx   = '0;
    for (int s = int'(SLOT_COUNT) - 1; s >= 0; s--) begin
      if (!slot_busy[s]) begin
        w_slot_found = 1'b1;
        w_slot_idx   = SW'(s);
      end
    end
  end

  // Winner position, offset to the muzzle and clamped to the visible area.
  logic [9:0]  w_win_x;
  logic [9:0]  w_win_y;
  logic [10:0] w_sum_x;
  logic [10:0] w_sum_y;
  logic [9:0]  w_start_x;
  logic [9:0]  w_start_y;

  always_comb begin
    w_win_x = enemy_x_flat[int'(w_win_idx)*10 +: 10];
    w_win_y = enemy_y_flat[int'(w_win_idx)*10 +: 10];
  end

  assign w_sum_x   = {1'b0, w_win_x} + XOffset;
  assign w_sum_y   = {1'b0, w_win_y} + YOffset;
  assign w_start_x = (w_sum_x > XMax) ? XMax[9:0] : w_sum_x[9:0];
  assign w_start_y = (w_sum_y > YMax) ? YMax[9:0] : w_sum_y[9:0];

  logic w_launch;
  assign w_launch = w_req_any && w_win_found && w_slot_found;

  always_ff @(posedge clk25 or posedge rst) begin
    if (rst) begin
      r_state       <= StIdle;
      r_rr_ptr      <= EW'(ENEMY_COUNT - 1);
      r_win         <= '0;
      r_spawn_valid <= 1'b0;
      r_spawn_slot  <= '0;
      r_spawn_x     <= '0;
      r_spawn_y     <= '0;
      r_fire_grant  <= '0;
`ifdef ENEMY_FIRE_COOLDOWN_EN
      r_cool_cnt    <= '0;
`endif
    end else begin
      // Grant is a pulse; it is only set on the handshake edge below.
      r_fire_grant <= '0;
      unique case (r_state)
        StIdle: begin
          if (w_launch) begin
            r_win         <= w_win_idx;
            r_spawn_slot  <= w_slot_idx;
            r_spawn_x     <= w_start_x;
            r_spawn_y     <= w_start_y;
            r_spawn_valid <= 1'b1;
            r_state       <= StSpawn;
          end
        end
        StSpawn: begin
          // Latched command completes regardless of later req/busy changes.
          if (spawn_ready) begin
            r_rr_ptr      <= r_win;
            r_fire_grant  <= ENEMY_COUNT'(1) << r_win;
            r_spawn_valid <= 1'b0;
`ifdef ENEMY_FIRE_COOLDOWN_EN
            r_cool_cnt    <= CW'(COOLDOWN_CYCLES - 1);
            r_state       <= StCooldown;
`else
            r_state       <= StIdle;
`endif
          end
        end
        StCooldown: begin
`ifdef ENEMY_FIRE_COOLDOWN_EN
          if (r_cool_cnt == '0) begin
            r_state <= StIdle;
          end else begin
            r_cool_cnt <= r_cool_cnt - 1'b1;
          end
`else
          r_state <= StIdle;
`endif
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign spawn_valid = r_spawn_valid;
  assign spawn_slot  = r_spawn_slot;
  assign spawn_x     = r_spawn_x;
  assign spawn_y     = r_spawn_y;
  assign fire_grant  = r_fire_grant;

endmodule

// File: doc/enemy_fire_scheduler.md
ENEMY_FIRE_SCHEDULER -- requirements
Module: enemy_fire_scheduler

Interface
REQ-001 SHALL have parameter ENEMY_COUNT, default 8, number of enemy fire requesters.
REQ-002 SHALL have parameter SLOT_COUNT, default 4, number of shared enemy-bullet slots; SLOT_COUNT >= 2.
REQ-003 SHALL have parameter COOLDOWN_CYCLES, default 25000, minimum gap in clk25 cycles between spawns (used only under REQ-027).
REQ-004 SHALL have port clk25  input  1  single system clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port fire_req  input  ENEMY_COUNT  level request per enemy, bit i = enemy i.
REQ-007 SHALL have port enemy_x_flat  input  10*ENEMY_COUNT  enemy i x at [i*10 +: 10].
REQ-008 SHALL have port enemy_y_flat  input  10*ENEMY_COUNT  enemy i y at [i*10 +: 10].
REQ-009 SHALL have port slot_busy  input  SLOT_COUNT  bit s high = slot s in flight in the bullet pool.
REQ-010 SHALL have port spawn_ready  input  1  bullet pool accepts the presented spawn this cycle.
REQ-011 SHALL have port spawn_valid  output  1  spawn command presented.
REQ-012 SHALL have port spawn_slot  output  $clog2(SLOT_COUNT)  target slot index.
REQ-013 SHALL have port spawn_x  output  10  bullet start x.
REQ-014 SHALL have port spawn_y  output  10  bullet start y.
REQ-015 SHALL have port fire_grant  output  ENEMY_COUNT  one-hot, one-cycle pulse to the enemy whose shot was accepted.

Function
REQ-016 SHALL implement states IDLE, SPAWN, COOLDOWN; COOLDOWN reachable only under REQ-027.
REQ-017 SHALL in IDLE, when any fire_req bit is high and any slot_busy bit is low, latch winner, slot and coordinates and enter SPAWN on the same edge; otherwise stay in IDLE with all latched state unchanged.
REQ-018 SHALL pick the winner round-robin: first requesting index searching upward from rr_ptr+1, wrapping from ENEMY_COUNT-1 to 0; rr_ptr included last.
REQ-019 SHALL pick the lowest-index slot with slot_busy low.
REQ-020 SHALL compute spawn_x = enemy_x + 12 and spawn_y = enemy_y + 16 in 11-bit arithmetic, saturating x at 639 and y at 479.
REQ-021 SHALL assert spawn_valid throughout SPAWN with spawn_slot/x/y held stable until the handshake edge (spawn_valid and spawn_ready high).
REQ-022 SHALL on the handshake edge set rr_ptr to the winner, drive fire_grant one-hot on the winner for exactly the next cycle, deassert spawn_valid, and go to IDLE (or COOLDOWN per REQ-027).
REQ-023 SHALL complete a latched spawn even if the winner's fire_req or the chosen slot's slot_busy changes during SPAWN.
REQ-024 SHALL ignore spawn_ready outside SPAWN.
REQ-025 SHALL produce minimum request-to-spawn_valid latency of 1 cycle and at most one spawn per 2 cycles without cooldown.

Reset
REQ-026 SHALL on rst high, asynchronously and regardless of state or spawn_ready, force state IDLE, rr_ptr = ENEMY_COUNT-1, spawn_valid = 0, spawn_slot = 0, spawn_x = 0, spawn_y = 0, fire_grant = 0, cooldown counter = 0; rst mid-SPAWN abandons the spawn with no grant.

Configuration
REQ-027 SHALL, with macro ENEMY_FIRE_COOLDOWN_EN defined, enter COOLDOWN after each handshake, load counter with COOLDOWN_CYCLES-1, decrement each cycle, and return to IDLE when it reads 0, ignoring all requests meanwhile; without the macro, return directly to IDLE and contain no cooldown counter.

Verification
REQ-028 SHALL cover: fire_req=8'b0000_0100, enemy 2 at (100,50), slot_busy=4'b0001, spawn_ready=1 -> spawn_valid next cycle, slot 1, (112,66), fire_grant=8'b0000_0100 one cycle after handshake.
REQ-029 SHALL cover: fire_req=8'hFF held, slots always free, no cooldown macro -> grants in order 0,1,...,7,0 one every 2 cycles.
REQ-030 SHALL cover: slot_busy=4'b1111 with fire_req=8'h01 -> spawn_valid stays 0; clearing slot 3 -> spawn on slot 3.
REQ-031 SHALL cover: enemy at (635,470) -> spawn_x=639, spawn_y=479; spawn_ready held low 10 cycles -> outputs stable, then accepted.
REQ-032 SHALL cover: rst pulsed mid-SPAWN -> spawn_valid=0 immediately, no fire_grant, next winner searched from 0.
REQ-033 SHALL cover: ENEMY_FIRE_COOLDOWN_EN, COOLDOWN_CYCLES=5, fire_req=8'hFF -> successive handshakes exactly 7 cycles apart (handshake, 5 cooldown cycles, IDLE, then SPAWN).
